// File: rtl/program_sequencer_pkg.sv
// Shared definitions for the program sequencer and the processor control unit:
// instruction opcodes, word width and the sequencer FSM state encoding.
package program_sequencer_pkg;

  localparam int WORD_W = 9;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_IMM   = 2'd2,
    S_WAIT  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/seq_prog_mem.sv
// Program store for the sequencer: one synchronous write port and one
// combinational read port.
module seq_prog_mem
  import program_sequencer_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WORD_W-1:0]        i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WORD_W-1:0]        o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];

  // NOTE: the array has no reset branch so a loaded program survives Resetn.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/program_sequencer.sv
// Feeds a stored program word by word to a processor over DIN/Run, handling
// mvi immediates, the Done handshake and a per-instruction timeout.
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [WORD_W-1:0]        ld_data,
  input  logic [$clog2(DEPTH):0]   prog_len,
  input  logic                     start,
  input  logic                     Done,
  output logic [WORD_W-1:0]        DIN,
  output logic                     Run,
  output logic                     busy,
  output logic                     prog_done,
  output logic                     err,
  output logic [$clog2(DEPTH)-1:0] pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   LEN_MAX  = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  seq_state_t        r_state;
  logic [AW-1:0]     r_pc;
  logic [AW:0]       r_len;
  logic [TW-1:0]     r_tmo;
  logic [WORD_W-1:0] r_din;
  logic              r_run;
  logic              r_prog_done;
  logic              r_err;

  logic              w_idle;
  logic              w_we;
  logic [AW-1:0]     w_pc_inc;
  logic [AW-1:0]     w_rd_addr;
  logic [AW:0]       w_pc_ext_inc;
  logic [AW:0]       w_len_clamped;
  logic [WORD_W-1:0] w_rd_data;
  logic [WORD_W-1:0] w_first_word;
  logic              w_is_mvi;
  logic              w_has_imm;
  logic              w_last;
  logic              w_retire;

  assign w_idle        = (r_state == S_IDLE);
  assign w_we          = ld_en && w_idle;
  assign w_pc_inc      = r_pc + 1'b1;
  assign w_pc_ext_inc  = {1'b0, r_pc} + 1'b1;
  assign w_rd_addr     = w_idle ? '0 : w_pc_inc;
  assign w_len_clamped = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
  assign w_is_mvi      = (r_din[2:0] == OP_MVI);
  assign w_has_imm     = (w_pc_ext_inc < r_len);
  assign w_last        = (w_pc_ext_inc == r_len);

  // A word written to address 0 on the start cycle must reach the first ISSUE.
  assign w_first_word  = (w_we && ld_addr == '0) ? ld_data : w_rd_data;

  // An mvi in ISSUE always fetches its immediate first; Done there is ignored.
  assign w_retire = Done && ((r_state == S_ISSUE && !w_is_mvi) ||
                             r_state == S_IMM || r_state == S_WAIT);

  seq_prog_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (Clock),
    .i_we    (w_we),
    .i_waddr (ld_addr),
    .i_wdata (ld_data),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_len       <= '0;
      r_tmo       <= '0;
      r_din       <= '0;
      r_run       <= 1'b0;
      r_prog_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_prog_done <= 1'b0;
      if (w_retire) begin
        r_pc  <= w_pc_inc;
        r_tmo <= '0;
        if (w_last) begin
          r_prog_done <= 1'b1;
          r_state     <= S_IDLE;
          r_run       <= 1'b0;
          r_din       <= '0;
        end else begin
          r_state <= S_ISSUE;
          r_din   <= w_rd_data;
        end
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_err <= 1'b0;
              r_pc  <= '0;
              r_tmo <= '0;
              if (prog_len != '0) begin
                r_len   <= w_len_clamped;
                r_state <= S_ISSUE;
                r_run   <= 1'b1;
                r_din   <= w_first_word;
              end else begin
                r_prog_done <= 1'b1;
              end
            end
          end
          S_ISSUE: begin
            if (w_is_mvi && !w_has_imm) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
              r_run   <= 1'b0;
              r_din   <= '0;
            end else if (w_is_mvi) begin
              r_pc    <= w_pc_inc;
              r_din   <= w_rd_data;
              r_state <= S_IMM;
            end else begin
              r_state <= S_WAIT;
            end
          end
          S_IMM: r_state <= S_WAIT;
          S_WAIT: begin
            if (r_tmo == TMO_LAST) begin
              r_err   <= 1'b1;
              r_state <= S_IDLE;
              r_run   <= 1'b0;
              r_din   <= '0;
              r_tmo   <= '0;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign DIN       = r_din;
  assign Run       = r_run;
  assign busy      = !w_idle;
  assign prog_done = r_prog_done;
  assign err       = r_err;
  assign pc        = r_pc;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: each task drives one scenario and
// compares outputs on the falling edge against hand-computed values.
module tb_program_sequencer;

  localparam int DEPTH   = 32;
  localparam int TIMEOUT = 15;
  localparam int AW      = 5;

  logic          Clock    = 1'b0;
  logic          Resetn   = 1'b0;
  logic          ld_en    = 1'b0;
  logic [AW-1:0] ld_addr  = '0;
  logic [8:0]    ld_data  = '0;
  logic [AW:0]   prog_len = '0;
  logic          start    = 1'b0;
  logic          Done     = 1'b0;
  logic [8:0]    DIN;
  logic          Run;
  logic          busy;
  logic          prog_done;
  logic          err;
  logic [AW-1:0] pc;

  int n_vec = 0;
  int n_err = 0;

  program_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .prog_len  (prog_len),
    .start     (start),
    .Done      (Done),
    .DIN       (DIN),
    .Run       (Run),
    .busy      (busy),
    .prog_done (prog_done),
    .err       (err),
    .pc        (pc)
  );

  always #5 Clock = ~Clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // All helpers start and end just after a falling edge.
  task automatic load_word(input logic [AW-1:0] a, input logic [8:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge Clock);
    ld_en = 1'b0;
  endtask

  task automatic start_prog(input logic [AW:0] len);
    prog_len = len; start = 1'b1;
    @(negedge Clock);
    start = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge Clock);
    n_vec++; if (DIN !== 9'h000) begin n_err++; $display("FAIL reset_din: got %h want 000", DIN); end
    n_vec++; if (Run !== 1'b0) begin n_err++; $display("FAIL reset_run: got %b want 0", Run); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (prog_done !== 1'b0) begin n_err++; $display("FAIL reset_prog_done: got %b want 0", prog_done); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err); end
    n_vec++; if (pc !== 5'd0) begin n_err++; $display("FAIL reset_pc: got %0d want 0", pc); end
    Resetn = 1'b1;
    @(negedge Clock);
  endtask

  task automatic test_mvi_program;
    load_word(5'd0, 9'h0C1);
    load_word(5'd1, 9'h1CF);
    start_prog(6'd2);
    n_vec++; if (DIN !== 9'h0C1) begin n_err++; $display("FAIL mvi_issue_din: got %h want 0c1", DIN); end
    n_vec++; if (Run !== 1'b1) begin n_err++; $display("FAIL mvi_issue_run: got %b want 1", Run); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mvi_issue_busy: got %b want 1", busy); end
    n_vec++; if (pc !== 5'd0) begin n_err++; $display("FAIL mvi_issue_pc: got %0d want 0", pc); end
    @(negedge Clock);
    n_vec++; if (DIN !== 9'h1CF) begin n_err++; $display("FAIL mvi_imm_din: got %h want 1cf", DIN); end
    n_vec++; if (pc !== 5'd1) begin n_err++; $display("FAIL mvi_imm_pc: got %0d want 1", pc); end
    @(negedge Clock);
    n_vec++; if (DIN !== 9'h1CF) begin n_err++; $display("FAIL mvi_wait_din: got %h want 1cf", DIN); end
    n_vec++; if (Run !== 1'b1) begin n_err++; $display("FAIL mvi_wait_run: got %b want 1", Run); end
    @(negedge Clock);
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
    n_vec++; if (prog_done !== 1'b1) begin n_err++; $display("FAIL mvi_prog_done: got %b want 1", prog_done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mvi_end_busy: got %b want 0", busy); end
    n_vec++; if (Run !== 1'b0) begin n_err++; $display("FAIL mvi_end_run: got %b want 0", Run); end
    n_vec++; if (DIN !== 9'h000) begin n_err++; $display("FAIL mvi_end_din: got %h want 000", DIN); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL mvi_end_err: got %b want 0", err); end
    n_vec++; if (pc !== 5'd2) begin n_err++; $display("FAIL mvi_end_pc: got %0d want 2", pc); end
    @(negedge Clock);
    n_vec++; if (prog_done !== 1'b0) begin n_err++; $display("FAIL mvi_done_pulse: got %b want 0", prog_done); end
  endtask

  // Word 0 is rewritten in the same cycle as start; ISSUE must see the new word.
  task automatic test_single_mv;
    ld_en = 1'b1; ld_addr = 5'd0; ld_data = 9'h02A; prog_len = 6'd1; start = 1'b1;
    @(negedge Clock);
    ld_en = 1'b0; start = 1'b0;
    n_vec++; if (DIN !== 9'h02A) begin n_err++; $display("FAIL mv_issue_din: got %h want 02a", DIN); end
    n_vec++; if (Run !== 1'b1) begin n_err++; $display("FAIL mv_issue_run: got %b want 1", Run); end
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
    n_vec++; if (prog_done !== 1'b1) begin n_err++; $display("FAIL mv_prog_done: got %b want 1", prog_done); end
    n_vec++; if (Run !== 1'b0) begin n_err++; $display("FAIL mv_end_run: got %b want 0", Run); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mv_end_busy: got %b want 0", busy); end
    n_vec++; if (pc !== 5'd1) begin n_err++; $display("FAIL mv_end_pc: got %0d want 1", pc); end
    @(negedge Clock);
    n_vec++; if (prog_done !== 1'b0) begin n_err++; $display("FAIL mv_done_pulse: got %b want 0", prog_done); end
  endtask

  task automatic test_timeout;
    logic pd_seen;
    start_prog(6'd1);
    pd_seen = prog_done;
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(negedge Clock);
      pd_seen = pd_seen | prog_done;
    end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL tmo_last_wait_busy: got %b want 1", busy); end
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL tmo_early_err: got %b want 0", err); end
    n_vec++; if (Run !== 1'b1) begin n_err++; $display("FAIL tmo_last_wait_run: got %b want 1", Run); end
    @(negedge Clock);
    pd_seen = pd_seen | prog_done;
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL tmo_err: got %b want 1", err); end
    n_vec++; if (Run !== 1'b0) begin n_err++; $display("FAIL tmo_run: got %b want 0", Run); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL tmo_busy: got %b want 0", busy); end
    n_vec++; if (DIN !== 9'h000) begin n_err++; $display("FAIL tmo_din: got %h want 000", DIN); end
    n_vec++; if (pd_seen !== 1'b0) begin n_err++; $display("FAIL tmo_no_prog_done: got %b want 0", pd_seen); end
    @(negedge Clock);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL tmo_err_sticky: got %b want 1", err); end
  endtask

  task automatic test_mvi_last;
    load_word(5'd0, 9'h0C1);
    start_prog(6'd1);
    n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL mvi_last_err_cleared: got %b want 0", err); end
    n_vec++; if (DIN !== 9'h0C1) begin n_err++; $display("FAIL mvi_last_din: got %h want 0c1", DIN); end
    @(negedge Clock);
    n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL mvi_last_err: got %b want 1", err); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mvi_last_busy: got %b want 0", busy); end
    n_vec++; if (Run !== 1'b0) begin n_err++; $display("FAIL mvi_last_run: got %b want 0", Run); end
    n_vec++; if (prog_done !== 1'b0) begin n_err++; $display("FAIL mvi_last_prog_done: got %b want 0", prog_done); end
  endtask

  task automatic test_zero_len;
    start_prog(6'd0);
    n_vec++; if (prog_done !== 1'b1) begin n_err++; $display("FAIL zero_prog_done: got %b want 1", prog_done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL zero_busy: got %b want 0", busy); end
    n_vec++; if (Run !== 1'b0) begin n_err++; $display("FAIL zero_run: got %b want 0", Run); end
    @(negedge Clock);
    n_vec++; if (prog_done !== 1'b0) begin n_err++; $display("FAIL zero_done_pulse: got %b want 0", prog_done); end
  endtask

  task automatic test_reset_mid;
    load_word(5'd0, 9'h02A);
    load_word(5'd1, 9'h0C1);
    load_word(5'd2, 9'h1CF);
    start_prog(6'd3);
    @(negedge Clock);
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
    n_vec++; if (DIN !== 9'h0C1) begin n_err++; $display("FAIL rst_issue1_din: got %h want 0c1", DIN); end
    n_vec++; if (pc !== 5'd1) begin n_err++; $display("FAIL rst_issue1_pc: got %0d want 1", pc); end
    @(negedge Clock);
    @(negedge Clock);
    n_vec++; if (DIN !== 9'h1CF) begin n_err++; $display("FAIL rst_wait_din: got %h want 1cf", DIN); end
    n_vec++; if (pc !== 5'd2) begin n_err++; $display("FAIL rst_wait_pc: got %0d want 2", pc); end
    Resetn = 1'b0;
    #1;
    n_vec++; if (DIN !== 9'h000) begin n_err++; $display("FAIL rst_async_din: got %h want 000", DIN); end
    n_vec++; if (Run !== 1'b0) begin n_err++; $display("FAIL rst_async_run: got %b want 0", Run); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_async_busy: got %b want 0", busy); end
    n_vec++; if (pc !== 5'd0) begin n_err++; $display("FAIL rst_async_pc: got %0d want 0", pc); end
    @(negedge Clock);
    Resetn = 1'b1;
    @(negedge Clock);
    n_vec++; if (prog_done !== 1'b0) begin n_err++; $display("FAIL rst_no_prog_done: got %b want 0", prog_done); end
    start_prog(6'd3);
    n_vec++; if (DIN !== 9'h02A) begin n_err++; $display("FAIL rst_replay_din: got %h want 02a", DIN); end
    n_vec++; if (pc !== 5'd0) begin n_err++; $display("FAIL rst_replay_pc: got %0d want 0", pc); end
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
    n_vec++; if (DIN !== 9'h0C1) begin n_err++; $display("FAIL rst_replay1_din: got %h want 0c1", DIN); end
    @(negedge Clock);
    n_vec++; if (DIN !== 9'h1CF) begin n_err++; $display("FAIL rst_replay_imm_din: got %h want 1cf", DIN); end
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
    n_vec++; if (prog_done !== 1'b1) begin n_err++; $display("FAIL rst_replay_done: got %b want 1", prog_done); end
    n_vec++; if (pc !== 5'd3) begin n_err++; $display("FAIL rst_replay_end_pc: got %0d want 3", pc); end
  endtask

  task automatic test_busy_ignore;
    start_prog(6'd3);
    @(negedge Clock);
    start = 1'b1; ld_en = 1'b1; ld_addr = 5'd0; ld_data = 9'h1FF; prog_len = 6'd1;
    @(negedge Clock);
    start = 1'b0; ld_en = 1'b0;
    n_vec++; if (pc !== 5'd0) begin n_err++; $display("FAIL busy_pc: got %0d want 0", pc); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_busy: got %b want 1", busy); end
    n_vec++; if (DIN !== 9'h02A) begin n_err++; $display("FAIL busy_din: got %h want 02a", DIN); end
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_len_kept: got %b want 1", busy); end
    n_vec++; if (pc !== 5'd1) begin n_err++; $display("FAIL busy_next_pc: got %0d want 1", pc); end
    @(negedge Clock);
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
    n_vec++; if (prog_done !== 1'b1) begin n_err++; $display("FAIL busy_prog_done: got %b want 1", prog_done); end
    start_prog(6'd1);
    n_vec++; if (DIN !== 9'h02A) begin n_err++; $display("FAIL busy_mem_intact: got %h want 02a", DIN); end
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
    n_vec++; if (prog_done !== 1'b1) begin n_err++; $display("FAIL busy_rerun_done: got %b want 1", prog_done); end
  endtask

  // prog_len above DEPTH runs exactly DEPTH words and pc wraps back to 0.
  task automatic test_clamp;
    int         runs;
    logic       seen;
    logic [8:0] exp_w;
    for (int i = 0; i < DEPTH; i++) load_word(AW'(i), {i[5:0], 3'b010});
    runs = 0;
    seen = 1'b0;
    Done = 1'b1;
    start_prog(6'd40);
    for (int k = 0; k < 100 && !seen; k++) begin
      if (prog_done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (Run === 1'b1) begin
          exp_w = {runs[5:0], 3'b010};
          n_vec++; if (DIN !== exp_w) begin n_err++; $display("FAIL clamp_din[%0d]: got %h want %h", runs, DIN, exp_w); end
          runs++;
        end
        @(negedge Clock);
      end
    end
    Done = 1'b0;
    n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL clamp_finish: got %b want 1 within 100 cycles", seen); end
    n_vec++; if (runs != DEPTH) begin n_err++; $display("FAIL clamp_runs: got %0d want %0d", runs, DEPTH); end
    n_vec++; if (pc !== 5'd0) begin n_err++; $display("FAIL clamp_pc_wrap: got %0d want 0", pc); end
  endtask

  initial begin
    test_reset();
    test_mvi_program();
    test_single_mv();
    test_timeout();
    test_mvi_last();
    test_zero_len();
    test_reset_mid();
    test_busy_ignore();
    test_clamp();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
